// File: rtl/path_delay_pulse_filter.sv
// ---------------------------------------------------------------------------
// path_delay_pulse_filter
//
// Cycle-based model of one module path (in => out). It has rise/fall delays
// and pulse reject/error limits. A two-entry schedule holds pending output
// transitions. Narrow pulses are dropped, or marked unknown (X). A third
// pending edge that finds both entries busy flushes the schedule and marks
// the output unknown.
//
// Ports
//   clk             sampling clock, all time counted in cycles
//   rst             synchronous active-high reset
//   in              path source, sampled every rising edge
//   rise_delay      delay for a 0->1 edge (0 behaves as 1)
//   fall_delay      delay for a 1->0 edge (0 behaves as 1)
//   reject_limit    pulses narrower than this are dropped
//   error_limit     pulses narrower than this (not rejected) give X;
//                   raised to reject_limit when smaller
//   ondetect        1: X at detection time, 0: X at the pulse's due time
//   out             delayed output value
//   out_x           output-unknown flag
//   pulse_rejected  one-cycle strobe, the cycle after a rejecting edge
//   pulse_error     one-cycle strobe, the cycle after an error/overflow edge
//   error_count     saturating count of error and overflow events
// ---------------------------------------------------------------------------
module path_delay_pulse_filter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in,
    input  logic [W-1:0] rise_delay,
    input  logic [W-1:0] fall_delay,
    input  logic [W-1:0] reject_limit,
    input  logic [W-1:0] error_limit,
    input  logic         ondetect,
    output logic         out,
    output logic         out_x,
    output logic         pulse_rejected,
    output logic         pulse_error,
    output logic [W-1:0] error_count
);

    localparam logic [W-1:0] ONES  = {W{1'b1}};
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    // rem: cycles left until the slot drives the output (matures at 1).
    // age: cycles since the slot's edge, saturating.
    typedef struct packed {
        logic         vld;
        logic         val;
        logic         x;
        logic [W-1:0] rem;
        logic [W-1:0] age;
    } slot_t;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        sat_inc = (v == ONES) ? v : v + ONE_W;
    endfunction

    function automatic slot_t advance(input slot_t s);
        advance     = s;
        advance.rem = s.rem - ONE_W;
        advance.age = sat_inc(s.age);
    endfunction

    logic         in_q;
    logic         out_q, out_d;
    logic         out_x_q, out_x_d;
    slot_t        a_q, a_d;
    slot_t        b_q, b_d;
    logic         det_rej_q, det_rej_d;
    logic         det_err_q, det_err_d;
    logic         pulse_rejected_q;
    logic         pulse_error_q;
    logic [W-1:0] err_cnt_q, err_cnt_d;

    logic         in_edge;
    logic         a_mat, b_mat;
    logic         ovf;
    logic [W-1:0] elim;
    logic [W-1:0] s_age;
    slot_t        new_slot;

    always_comb begin
        in_edge      = in ^ in_q;
        new_slot.vld = 1'b1;
        new_slot.val = in;
        new_slot.x   = 1'b0;
        new_slot.rem = in ? rise_delay : fall_delay;
        if (new_slot.rem == '0) new_slot.rem = ONE_W;
        // Age 0 at load; after one advance it equals the edge-to-edge width.
        new_slot.age = '0;
        elim = (error_limit < reject_limit) ? reject_limit : error_limit;

        // Maturity first: the younger slot is applied last so it wins.
        a_mat   = a_q.vld && (a_q.rem == ONE_W);
        b_mat   = b_q.vld && (b_q.rem == ONE_W);
        out_d   = out_q;
        out_x_d = out_x_q;
        if (a_mat) begin
            out_d   = a_q.val;
            out_x_d = a_q.x;
        end
        if (b_mat) begin
            out_d   = b_q.val;
            out_x_d = b_q.x;
        end

        // Surviving slots, compacted so a_d is always the older one.
        a_d = '0;
        b_d = '0;
        if (a_q.vld && !a_mat) begin
            a_d = advance(a_q);
            if (b_q.vld && !b_mat) b_d = advance(b_q);
        end else if (b_q.vld && !b_mat) begin
            a_d = advance(b_q);
        end

        det_rej_d = 1'b0;
        det_err_d = 1'b0;
        ovf       = 1'b0;
        s_age     = b_d.vld ? b_d.age : a_d.age;

        if (in_edge) begin
            if (!a_d.vld) begin
                a_d = new_slot;
            end else if (s_age < reject_limit) begin
                det_rej_d = 1'b1;
                if (b_d.vld) b_d.vld = 1'b0;
                else         a_d.vld = 1'b0;
            end else if (s_age < elim) begin
                det_err_d = 1'b1;
                if (ondetect) begin
                    // The unknown pulse is replaced by the new edge at once.
                    out_x_d = 1'b1;
                    if (b_d.vld) b_d = new_slot;
                    else         a_d = new_slot;
                end else if (b_d.vld) begin
                    ovf = 1'b1;
                end else begin
                    a_d.x = 1'b1;
                    b_d   = new_slot;
                end
            end else if (b_d.vld) begin
                ovf = 1'b1;
            end else begin
                b_d = new_slot;
            end

            if (ovf) begin
                a_d       = new_slot;
                b_d       = '0;
                out_x_d   = 1'b1;
                det_err_d = 1'b1;
            end
        end

        err_cnt_d = det_err_d ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q             <= 1'b0;
            out_q            <= 1'b0;
            out_x_q          <= 1'b0;
            a_q              <= '0;
            b_q              <= '0;
            det_rej_q        <= 1'b0;
            det_err_q        <= 1'b0;
            pulse_rejected_q <= 1'b0;
            pulse_error_q    <= 1'b0;
            err_cnt_q        <= '0;
        end else begin
            in_q             <= in;
            out_q            <= out_d;
            out_x_q          <= out_x_d;
            a_q              <= a_d;
            b_q              <= b_d;
            det_rej_q        <= det_rej_d;
            det_err_q        <= det_err_d;
            // Strobes appear the cycle after the detecting edge.
            pulse_rejected_q <= det_rej_q;
            pulse_error_q    <= det_err_q;
            err_cnt_q        <= err_cnt_d;
        end
    end

    assign out            = out_q;
    assign out_x          = out_x_q;
    assign pulse_rejected = pulse_rejected_q;
    assign pulse_error    = pulse_error_q;
    assign error_count    = err_cnt_q;

endmodule

// File: tb/tb_path_delay_pulse_filter.sv
// ---------------------------------------------------------------------------
// Bench for path_delay_pulse_filter. A reference model keeps the pending
// transitions as a queue of absolute due times. Directed scenarios run first.
// A randomized phase and an error-count saturation phase follow. Every cycle
// is compared against the model.
// ---------------------------------------------------------------------------
module tb_path_delay_pulse_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_s = 1'b0;
    logic [7:0] rise_delay = 8'd1;
    logic [7:0] fall_delay = 8'd1;
    logic [7:0] reject_limit = 8'd0;
    logic [7:0] error_limit = 8'd0;
    logic       ondetect = 1'b0;
    logic       out, out_x, pulse_rejected, pulse_error;
    logic [7:0] error_count;

    path_delay_pulse_filter #(.W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in             (in_s),
        .rise_delay     (rise_delay),
        .fall_delay     (fall_delay),
        .reject_limit   (reject_limit),
        .error_limit    (error_limit),
        .ondetect       (ondetect),
        .out            (out),
        .out_x          (out_x),
        .pulse_rejected (pulse_rejected),
        .pulse_error    (pulse_error),
        .error_count    (error_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic val;
        logic x;
        int   due;
        int   t0;
    } ev_t;

    ev_t  pend[$];
    int   m_t = 0;
    logic m_inq = 0, m_out = 0, m_x = 0;
    logic m_rejp = 0, m_errp = 0, m_prej = 0, m_perr = 0;
    int   m_cnt = 0;

    task automatic err_event();
        m_errp = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_step();
        int   d, el, w, i;
        ev_t  ne;
        if (rst) begin
            pend.delete();
            m_inq = 0; m_out = 0; m_x = 0;
            m_rejp = 0; m_errp = 0; m_prej = 0; m_perr = 0; m_cnt = 0;
            m_t++;
            return;
        end
        m_prej = m_rejp;
        m_perr = m_errp;
        m_rejp = 0;
        m_errp = 0;
        i = 0;
        while (i < pend.size()) begin
            if (pend[i].due == m_t) begin
                m_out = pend[i].val;
                m_x   = pend[i].x;
                pend.delete(i);
            end else begin
                i++;
            end
        end
        if (in_s !== m_inq) begin
            d = in_s ? int'(rise_delay) : int'(fall_delay);
            if (d == 0) d = 1;
            ne.val = in_s; ne.x = 1'b0; ne.due = m_t + d; ne.t0 = m_t;
            el = (error_limit < reject_limit) ? int'(reject_limit) : int'(error_limit);
            if (pend.size() == 0) begin
                pend.push_back(ne);
            end else begin
                w = m_t - pend[pend.size()-1].t0;
                if (w < int'(reject_limit)) begin
                    void'(pend.pop_back());
                    m_rejp = 1'b1;
                end else if (w < el && ondetect) begin
                    err_event();
                    m_x = 1'b1;
                    void'(pend.pop_back());
                    pend.push_back(ne);
                end else begin
                    if (w < el) begin
                        err_event();
                        pend[pend.size()-1].x = 1'b1;
                    end
                    if (pend.size() < 2) begin
                        pend.push_back(ne);
                    end else begin
                        pend.delete();
                        pend.push_back(ne);
                        m_x = 1'b1;
                        if (!m_errp) err_event();
                    end
                end
            end
        end
        m_inq = in_s;
        m_t++;
    endtask

    // One clock: drive, clock, update model, compare.
    task automatic tick(input logic in_v, input logic rst_v);
        @(negedge clk);
        in_s = in_v;
        rst  = rst_v;
        @(posedge clk);
        model_step();
        #1;
        chk("out", out, m_out);
        chk("out_x", out_x, m_x);
        chk("pulse_rejected", pulse_rejected, m_prej);
        chk("pulse_error", pulse_error, m_perr);
        chk("error_count", error_count, m_cnt);
    endtask

    task automatic setup(input int r, input int f, input int rj, input int er, input logic od);
        rise_delay   = 8'(r);
        fall_delay   = 8'(f);
        reject_limit = 8'(rj);
        error_limit  = 8'(er);
        ondetect     = od;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw1;
        logic cur;
        int   tp;

        // Plain delay (k=0 is the reset edge).
        setup(3, 5, 0, 0, 0);
        tick(1'b0, 1'b1);
        chk("reset_out", out, 0);
        chk("reset_cnt", error_count, 0);
        for (int k = 1; k <= 30; k++) begin
            tick((k >= 10 && k < 20), 1'b0);
            if (k == 12) chk("plain_out12", out, 0);
            if (k == 13) chk("plain_out13", out, 1);
            if (k == 24) chk("plain_out24", out, 1);
            if (k == 25) chk("plain_out25", out, 0);
        end

        // Inertial reject.
        setup(6, 6, 6, 6, 0);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick((k >= 10 && k < 12), 1'b0);
            if (k == 12) chk("rej_strobe12", pulse_rejected, 0);
            if (k == 13) chk("rej_strobe13", pulse_rejected, 1);
            if (k == 16) chk("rej_out16", out, 0);
            if (k == 30) chk("rej_cnt", error_count, 0);
        end

        // Error band, on-event.
        setup(8, 8, 2, 6, 0);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick((k >= 10 && k < 14), 1'b0);
            if (k == 17) chk("ev_x17", out_x, 0);
            if (k == 18) chk("ev_x18", out_x, 1);
            if (k == 21) chk("ev_x21", out_x, 1);
            if (k == 22) chk("ev_x22", out_x, 0);
            if (k == 22) chk("ev_out22", out, 0);
            if (k == 30) chk("ev_cnt", error_count, 1);
        end

        // Error band, on-detect.
        setup(8, 8, 2, 6, 1);
        tick(1'b0, 1'b1);
        saw1 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick((k >= 10 && k < 14), 1'b0);
            saw1 = saw1 | out;
            if (k == 13) chk("od_x13", out_x, 0);
            if (k == 14) chk("od_x14", out_x, 1);
            if (k == 21) chk("od_x21", out_x, 1);
            if (k == 22) chk("od_x22", out_x, 0);
        end
        chk("od_never1", saw1, 0);

        // Transport and overflow.
        setup(10, 10, 2, 2, 0);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick(((k >= 10 && k < 13) || k >= 16), 1'b0);
            if (k == 16) chk("ovf_x16", out_x, 1);
            if (k == 25) chk("ovf_out25", out, 0);
            if (k == 26) chk("ovf_out26", out, 1);
            if (k == 26) chk("ovf_x26", out_x, 0);
            if (k == 30) chk("ovf_cnt", error_count, 1);
        end

        // Reset mid-flight.
        setup(7, 7, 0, 0, 0);
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 25; k++) begin
            tick((k >= 10), (k == 12));
            if (k == 17) chk("rst_out17", out, 0);
            if (k == 17) chk("rst_cnt17", error_count, 0);
            if (k == 20) chk("rst_out20", out, 1);
        end

        // Randomized blocks.
        for (int blk = 0; blk < 20; blk++) begin
            setup($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 6),
                  $urandom_range(0, 8), 1'($urandom_range(0, 1)));
            tp  = $urandom_range(1, 5);
            cur = 1'b0;
            tick(1'b0, 1'b1);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, tp) == 0) cur = ~cur;
                if ($urandom_range(0, 19) == 0) begin
                    rise_delay = 8'($urandom_range(0, 12));
                    fall_delay = 8'($urandom_range(0, 12));
                end
                if ($urandom_range(0, 29) == 0) begin
                    reject_limit = 8'($urandom_range(0, 6));
                    error_limit  = 8'($urandom_range(0, 8));
                end
                tick(cur, ($urandom_range(0, 199) == 0));
            end
        end

        // Error-count saturation: every second edge overflows.
        setup(40, 40, 0, 0, 0);
        tick(1'b0, 1'b1);
        cur = 1'b0;
        for (int c = 0; c < 600; c++) begin
            cur = ~cur;
            tick(cur, 1'b0);
        end
        chk("cnt_saturated", error_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
